aesl_deadlock_trace_unit: RTL and testbench
===========================================

AESL_DEADLOCK_TRACE_UNIT -- requirements
Module: aesl_deadlock_trace_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4, number of monitored processes (2..32).
REQ-002 SHALL have parameter CONFIRM_CYC, default 16, cycles dl_in_vec must stay non-zero before detection (>=1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, record FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter TS_W, default 32, timestamp width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clock  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low.
REQ-007 SHALL have port dl_in_vec  in  PROC_NUM  per-process blocked flags.
REQ-008 SHALL have port dl_detect_out  out  1  deadlock confirmed, sticky.
REQ-009 SHALL have port origin  out  PROC_NUM  one-hot start of the current circle, valid in DETECTED only.
REQ-010 SHALL have port token_clear  out  1  circle-closed pulse.
REQ-011 SHALL have ports rec_valid out 1 and rec_ready in 1, the record FIFO read handshake.
REQ-012 SHALL have record ports rec_proc out PROC_NUM (one-hot), rec_circle out 8, rec_first out 1, rec_last out 1 and rec_ts out TS_W.
REQ-013 SHALL have ports rec_overflow out 1 (sticky drop flag) and report_done out 1 (all circles reported, sticky).

Function
REQ-014 SHALL implement FSM states IDLE, CONFIRM, DETECTED, REPORT and DONE.
REQ-015 SHALL handle IDLE: |dl_in_vec goes to CONFIRM, with cnt=1 and acc=dl_in_vec.
REQ-016 SHALL handle CONFIRM:
- dl_in_vec==0 returns to IDLE and clears acc.
- Otherwise acc|=dl_in_vec and cnt++.
- When cnt reaches CONFIRM_CYC, detect_reg<=acc|dl_in_vec and go to DETECTED.
- CONFIRM_CYC=1 goes IDLE->CONFIRM->DETECTED.
REQ-017 SHALL drive dl_detect_out = |detect_reg.
REQ-018 SHALL handle DETECTED:
- If detect_reg==done_reg, go to DONE.
- Otherwise origin = lowest set bit of detect_reg&~done_reg, for this cycle only.
- origin_reg<=origin and last_vec<=origin.
- Push record {proc=origin, first=1, last=0}.
- Go to REPORT.
REQ-019 SHALL handle REPORT when dl_in_vec&origin_reg==0:
- If dl_in_vec!=0 and dl_in_vec!=last_vec, push record {proc=lowest set bit of dl_in_vec, first=0, last=0}.
- last_vec<=dl_in_vec.
- Repeated identical vectors SHALL NOT push.
REQ-020 SHALL, in REPORT whenever dl_in_vec&detect_reg!=0, set done_reg|=dl_in_vec.
REQ-021 SHALL, in REPORT when dl_in_vec&origin_reg!=0:
- token_clear=1 combinationally.
- Push record {proc=origin_reg, first=0, last=1}.
- circle_id increments, saturating at 255.
- Go to DETECTED.
REQ-022 SHALL handle DONE: report_done=1, the FSM stays in DONE until reset, and no further pushes occur.
REQ-023 SHALL set rec_circle to circle_id, which starts at 1.
REQ-024 SHALL drive token_clear=0 and origin=0 in all states other than those above.
REQ-025 SHALL implement the FIFO as first-word-fall-through:
- rec_valid = not empty.
- A pop occurs on rec_valid&rec_ready.
REQ-026 SHALL, for a push when full:
- Accept the push if a pop occurs in the same cycle.
- Otherwise drop the record and set rec_overflow=1 until reset.
REQ-027 SHALL make push and pop on an empty FIFO write only, with rec_valid rising the next cycle.
REQ-028 SHALL NOT let FIFO state stall the FSM.

Reset
REQ-029 SHALL, on reset low, asynchronously clear:
- FSM to IDLE and cnt, acc, detect_reg, done_reg, origin_reg, last_vec to 0.
- circle_id to 1 and the FIFO to empty.
- rec_overflow, report_done and the timestamp counter to 0.
REQ-030 SHALL set all outputs to 0 while reset is asserted, including mid-circle.
REQ-031 SHALL keep no state across reset.

Configuration
REQ-032 SHALL gate the timestamp feature with macro AESL_DL_TIMESTAMP_EN.
- Defined: a TS_W-bit free-running counter increments every cycle after reset and wraps at 2^TS_W-1 to 0; each record captures the counter value at push and presents it on rec_ts.
- Undefined: the counter is absent and rec_ts is constant 0.

Verification
REQ-033 SHALL test glitch rejection: PROC_NUM=4, CONFIRM_CYC=4, dl_in_vec=0011 for 3 cycles then 0 -> FSM returns to IDLE, dl_detect_out=0, no records.
REQ-034 SHALL test a single circle: dl_in_vec=0011 held 4 cycles, then REPORT sequence 0010,0010,0001 -> records:
- {0001,first}
- {0010}
- {0001,last}
- token_clear for 1 cycle, circle 1, then report_done=1.
REQ-035 SHALL test two circles: detect_reg=0101 with circles 0->1->0 and 2->3->2 -> records carry circle 1 then 2, origins 0001 then 0100, report_done after the second last-record.
REQ-036 SHALL test overflow: FIFO_DEPTH=2, rec_ready=0, a 3-record circle -> 2 records held and rec_overflow=1. Repeat with rec_ready=1 on the third push cycle -> no overflow.
REQ-037 SHALL test reset mid-REPORT: reset low for 1 cycle -> all outputs 0, FIFO empty, and a new circle restarts at circle_id 1.
REQ-038 SHALL test timestamps with AESL_DL_TIMESTAMP_EN, TS_W=4: records pushed at cycles 3 and 17 after reset -> rec_ts 3 and 1 (wrapped). Without the macro -> rec_ts=0.

Source files
------------

// File: rtl/aesl_deadlock_trace_unit.sv
// Deadlock trace unit: confirms a persistent blocked vector, then walks each blocked circle and
// queues one trace record per hop. Record timestamps are enabled by AESL_DL_TIMESTAMP_EN.
module aesl_deadlock_trace_unit #(
    parameter int unsigned PROC_NUM    = 4,
    parameter int unsigned CONFIRM_CYC = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TS_W        = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [PROC_NUM-1:0] rec_proc,
    output logic [7:0]          rec_circle,
    output logic                rec_first,
    output logic                rec_last,
    output logic [TS_W-1:0]     rec_ts,
    output logic                rec_overflow,
    output logic                report_done
);

    localparam int unsigned CntW = $clog2(CONFIRM_CYC + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StConfirm, StDetected, StReport, StDone} state_e;

    typedef struct packed {
        logic [PROC_NUM-1:0] proc;
        logic [7:0]          circle;
        logic                first;
        logic                last;
`ifdef AESL_DL_TIMESTAMP_EN
        logic [TS_W-1:0]     ts;
`endif
    } rec_t;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [PROC_NUM-1:0] acc_q, detect_reg, done_reg, origin_reg, last_vec;
    logic [7:0]          circle_id;
    logic                report_done_q;
    logic [PROC_NUM-1:0] pending;
    logic                push;
    rec_t                push_rec;

    function automatic logic [PROC_NUM-1:0] lowest_bit(input logic [PROC_NUM-1:0] v);
        return v & (~v + PROC_NUM'(1));
    endfunction

`ifdef AESL_DL_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end
`endif

    assign pending = detect_reg & ~done_reg;

    always_comb begin
        origin          = '0;
        token_clear     = 1'b0;
        push            = 1'b0;
        push_rec        = '0;
        push_rec.circle = circle_id;
`ifdef AESL_DL_TIMESTAMP_EN
        push_rec.ts     = ts_q;
`endif
        case (state_q)
            StDetected: begin
                if (pending != '0) begin
                    origin         = lowest_bit(pending);
                    push           = 1'b1;
                    push_rec.proc  = lowest_bit(pending);
                    push_rec.first = 1'b1;
                end
            end
            StReport: begin
                if ((dl_in_vec & origin_reg) != '0) begin
                    token_clear   = 1'b1;
                    push          = 1'b1;
                    push_rec.proc = origin_reg;
                    push_rec.last = 1'b1;
                end else if (dl_in_vec != '0 && dl_in_vec != last_vec) begin
                    push          = 1'b1;
                    push_rec.proc = lowest_bit(dl_in_vec);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            detect_reg    <= '0;
            done_reg      <= '0;
            origin_reg    <= '0;
            last_vec      <= '0;
            circle_id     <= 8'd1;
            report_done_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (dl_in_vec != '0) begin
                        state_q <= StConfirm;
                        cnt_q   <= CntW'(1);
                        acc_q   <= dl_in_vec;
                    end
                end
                StConfirm: begin
                    if (dl_in_vec == '0) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end else if (32'(cnt_q) + 32'd1 >= 32'(CONFIRM_CYC)) begin
                        detect_reg <= acc_q | dl_in_vec;
                        state_q    <= StDetected;
                    end else begin
                        acc_q <= acc_q | dl_in_vec;
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDetected: begin
                    if (pending == '0) begin
                        state_q       <= StDone;
                        report_done_q <= 1'b1;
                    end else begin
                        origin_reg <= origin;
                        last_vec   <= origin;
                        state_q    <= StReport;
                    end
                end
                StReport: begin
                    // Only processes inside the detected set can retire a future origin.
                    done_reg <= done_reg | (dl_in_vec & detect_reg);
                    if (token_clear) begin
                        if (circle_id != 8'd255) circle_id <= circle_id + 8'd1;
                        state_q <= StDetected;
                    end else begin
                        last_vec <= dl_in_vec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dl_detect_out = |detect_reg;
    assign report_done   = report_done_q;

    rec_t            mem [FIFO_DEPTH];
    rec_t            head;
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [PtrW:0]   count;
    logic            full, pop, wr_en;

    assign full      = count == (PtrW + 1)'(FIFO_DEPTH);
    assign rec_valid = count != '0;
    assign pop       = rec_valid & rec_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign wr_en     = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rec_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)   rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + {{PtrW{1'b0}}, wr_en} - {{PtrW{1'b0}}, pop};
            if (push && !wr_en) rec_overflow <= 1'b1;
        end
    end

    assign head       = mem[rd_ptr];
    assign rec_proc   = rec_valid ? head.proc   : '0;
    assign rec_circle = rec_valid ? head.circle : '0;
    assign rec_first  = rec_valid ? head.first  : 1'b0;
    assign rec_last   = rec_valid ? head.last   : 1'b0;
`ifdef AESL_DL_TIMESTAMP_EN
    assign rec_ts     = rec_valid ? head.ts     : '0;
`else
    assign rec_ts     = '0;
`endif

endmodule

// File: tb/tb_aesl_deadlock_trace_unit.sv
// Bench for aesl_deadlock_trace_unit: directed circles plus randomized scenarios, with expected
// records derived from each scenario's circle plan.
module tb_aesl_deadlock_trace_unit;

    localparam int unsigned P  = 4;
    localparam int unsigned C  = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned TW = 4;

    logic          clock;
    logic          reset;
    logic [P-1:0]  dl_in_vec;
    logic          rec_ready;
    logic          dl_detect_out;
    logic [P-1:0]  origin;
    logic          token_clear;
    logic          rec_valid;
    logic [P-1:0]  rec_proc;
    logic [7:0]    rec_circle;
    logic          rec_first;
    logic          rec_last;
    logic [TW-1:0] rec_ts;
    logic          rec_overflow;
    logic          report_done;

    aesl_deadlock_trace_unit #(
        .PROC_NUM   (P),
        .CONFIRM_CYC(C),
        .FIFO_DEPTH (D),
        .TS_W       (TW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dl_in_vec    (dl_in_vec),
        .dl_detect_out(dl_detect_out),
        .origin       (origin),
        .token_clear  (token_clear),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_proc     (rec_proc),
        .rec_circle   (rec_circle),
        .rec_first    (rec_first),
        .rec_last     (rec_last),
        .rec_ts       (rec_ts),
        .rec_overflow (rec_overflow),
        .report_done  (report_done)
    );

    typedef struct packed {
        logic [3:0] proc;
        logic [7:0] circle;
        logic       first;
        logic       last;
        logic [3:0] ts;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       got_q[$];
    logic [3:0] conf_q[$];
    int         plan_q[$];   // 0..15: report vector, 16: close the circle
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;     // rising edges since reset release
    int         tc_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic rec_t mk(input logic [3:0] p, input int c, input logic f, input logic l,
                                input logic [3:0] t);
        rec_t r;
        r.proc = p; r.circle = 8'(c); r.first = f; r.last = l; r.ts = t;
        return r;
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] x);
        for (int i = 0; i < 4; i++) if (x[i]) return 4'(1 << i);
        return 4'd0;
    endfunction

    function automatic logic [3:0] ts_of(input int edge_idx);
`ifdef AESL_DL_TIMESTAMP_EN
        return 4'(edge_idx % 16);
`else
        return 4'(edge_idx * 0);
`endif
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            got_q.delete();
            tc_cnt = 0;
        end else begin
            if (rec_valid && rec_ready)
                got_q.push_back(mk(rec_proc, int'(rec_circle), rec_first, rec_last, rec_ts));
            if (token_clear) tc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; dl_in_vec = '0; rec_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        cyc = 0;
        exp_q.delete(); conf_q.delete(); plan_q.delete();
    endtask

    // Drives conf_q, then every circle from plan_q; expectations come from set arithmetic on
    // the detected vector and the reported hops.
    task automatic run_scenario(input string name);
        logic [3:0] det, done, org, prev, v;
        int circ, p, circles;
        det = '0; done = '0; circ = 1; circles = 0;
        for (int i = 0; i < conf_q.size(); i++) begin
            dl_in_vec = conf_q[i];
            det |= conf_q[i];
            if (i == conf_q.size() - 1) begin
                @(negedge clock);
                n_checks++;
                if (dl_detect_out !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s early_detect: got %b, required 0", name, dl_detect_out);
                end
            end
            tick();
        end
        while ((det & ~done) != 4'd0) begin
            org = lowest(det & ~done);
            dl_in_vec = 4'($urandom);
            @(negedge clock);
            n_checks++;
            if (origin !== org) begin
                n_errors++;
                $display("FAIL %s origin: got %b, required %b", name, origin, org);
            end
            exp_q.push_back(mk(org, circ, 1'b1, 1'b0, ts_of(cyc)));
            tick();
            prev = org;
            for (int k = 0; k < 64; k++) begin
                p = (plan_q.size() > 0) ? plan_q.pop_front() : 16;
                if (k == 63) p = 16;
                v = (p == 16) ? org : (4'(p) & ~org);
                dl_in_vec = v;
                @(negedge clock);
                n_checks++;
                if (token_clear !== (p == 16)) begin
                    n_errors++;
                    $display("FAIL %s token_clear: got %b, required %b", name, token_clear,
                             (p == 16));
                end
                if (p == 16) exp_q.push_back(mk(org, circ, 1'b0, 1'b1, ts_of(cyc)));
                else if (v != 4'd0 && v != prev)
                    exp_q.push_back(mk(lowest(v), circ, 1'b0, 1'b0, ts_of(cyc)));
                done |= v & det;
                prev = v;
                tick();
                if (p == 16) break;
            end
            circ = (circ < 255) ? circ + 1 : 255;
            circles++;
        end
        dl_in_vec = 4'($urandom);
        @(negedge clock);
        n_checks++;
        if (origin !== 4'd0) begin
            n_errors++;
            $display("FAIL %s origin_at_done: got %b, required 0000", name, origin);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            dl_in_vec = 4'($urandom);
            tick();
        end
        n_checks++;
        if ({report_done, dl_detect_out, rec_overflow, rec_valid} !== 4'b1100) begin
            n_errors++;
            $display("FAIL %s flags: got done/det/ovf/valid=%b, required 1100", name,
                     {report_done, dl_detect_out, rec_overflow, rec_valid});
        end
        n_checks++;
        if (tc_cnt != circles) begin
            n_errors++;
            $display("FAIL %s token_pulses: got %0d, required %0d", name, tc_cnt, circles);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s record_count: got %0d, required %0d", name, got_q.size(),
                     exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s record[%0d]: got proc=%b circ=%0d f=%b l=%b ts=%0d, required proc=%b circ=%0d f=%b l=%b ts=%0d",
                         name, i, got_q[i].proc, got_q[i].circle, got_q[i].first,
                         got_q[i].last, got_q[i].ts, exp_q[i].proc, exp_q[i].circle,
                         exp_q[i].first, exp_q[i].last, exp_q[i].ts);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; dl_in_vec = 4'b1111; rec_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({dl_detect_out, origin, token_clear, rec_valid, rec_proc, rec_circle, rec_first,
             rec_last, rec_ts, rec_overflow, report_done} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        apply_reset();
        repeat (3) tick();
        n_checks++;
        if ({dl_detect_out, rec_valid, report_done, rec_overflow} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_idle: got det/valid/done/ovf=%b, required 0000",
                     {dl_detect_out, rec_valid, report_done, rec_overflow});
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        repeat (3) begin dl_in_vec = 4'b0011; tick(); end
        repeat (6) begin dl_in_vec = 4'b0000; tick(); end
        n_checks++;
        if ({dl_detect_out, report_done, rec_valid} !== 3'b000 || got_q.size() != 0) begin
            n_errors++;
            $display("FAIL glitch: got det/done/valid=%b records=%0d, required 000 and 0",
                     {dl_detect_out, report_done, rec_valid}, got_q.size());
        end
    endtask

    task automatic test_single_circle();
        apply_reset();
        repeat (4) conf_q.push_back(4'b0011);
        plan_q = '{2, 2, 16};
        run_scenario("single_circle");
    endtask

    task automatic test_two_circles();
        apply_reset();
        repeat (4) conf_q.push_back(4'b0101);
        plan_q = '{2, 16, 8, 16};
        run_scenario("two_circles");
    endtask

    task automatic test_timestamp();
        apply_reset();
        repeat (4) conf_q.push_back(4'b0011);
        plan_q = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 16};
        run_scenario("timestamp");
    endtask

    task automatic test_overflow();
        apply_reset();
        rec_ready = 1'b0;
        repeat (4) begin dl_in_vec = 4'b0011; tick(); end
        dl_in_vec = 4'b0000; tick();
        dl_in_vec = 4'b0010; tick();
        dl_in_vec = 4'b0001; tick();
        dl_in_vec = 4'b0000; tick();
        @(negedge clock);
        n_checks++;
        if ({rec_overflow, rec_valid, report_done} !== 3'b111 || got_q.size() != 0) begin
            n_errors++;
            $display("FAIL overflow_flag: got ovf/valid/done=%b popped=%0d, required 111 and 0",
                     {rec_overflow, rec_valid, report_done}, got_q.size());
        end
        rec_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_errors++;
            $display("FAIL overflow_held: got %0d records, required 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].proc !== 4'b0001 || got_q[0].first !== 1'b1 ||
                got_q[1].proc !== 4'b0010 || got_q[1].last !== 1'b0) begin
                n_errors++;
                $display("FAIL overflow_content: got %b/%b, required 0001/0010",
                         got_q[0].proc, got_q[1].proc);
            end
        end
        apply_reset();
        rec_ready = 1'b0;
        repeat (4) begin dl_in_vec = 4'b0011; tick(); end
        dl_in_vec = 4'b0000; tick();
        dl_in_vec = 4'b0010; tick();
        dl_in_vec = 4'b0001; rec_ready = 1'b1; tick();
        rec_ready = 1'b0; dl_in_vec = 4'b0000; tick();
        @(negedge clock);
        n_checks++;
        if ({rec_overflow, rec_valid} !== 2'b01) begin
            n_errors++;
            $display("FAIL overflow_same_cycle_pop: got ovf/valid=%b, required 01",
                     {rec_overflow, rec_valid});
        end
        rec_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (got_q.size() != 3) begin
            n_errors++;
            $display("FAIL overflow_drain: got %0d records, required 3", got_q.size());
        end else begin
            n_checks++;
            if (got_q[2].proc !== 4'b0001 || got_q[2].last !== 1'b1) begin
                n_errors++;
                $display("FAIL overflow_last: got proc=%b last=%b, required 0001 1",
                         got_q[2].proc, got_q[2].last);
            end
        end
    endtask

    task automatic test_reset_mid_report();
        apply_reset();
        repeat (4) begin dl_in_vec = 4'b0011; tick(); end
        dl_in_vec = 4'b0000; tick();
        dl_in_vec = 4'b0010; tick();
        dl_in_vec = 4'b0001;
        #1;
        n_checks++;
        if (token_clear !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_report_token: got %b, required 1", token_clear);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({dl_detect_out, origin, token_clear, rec_valid, rec_proc, rec_circle, rec_first,
             rec_last, rec_ts, rec_overflow, report_done} !== '0) begin
            n_errors++;
            $display("FAIL mid_report_reset: got det=%b tc=%b valid=%b, required all 0",
                     dl_detect_out, token_clear, rec_valid);
        end
        apply_reset();
        repeat (4) conf_q.push_back(4'b0011);
        plan_q = '{4, 2, 16};
        run_scenario("after_reset");
    endtask

    task automatic test_random();
        for (int s = 0; s < 20; s++) begin
            apply_reset();
            repeat ($urandom_range(0, 3)) tick();
            repeat (4) conf_q.push_back(4'($urandom_range(1, 15)));
            repeat ($urandom_range(0, 12))
                plan_q.push_back(($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(0, 15)));
            run_scenario($sformatf("random%0d", s));
        end
    endtask

    initial begin
        reset = 1'b0; dl_in_vec = '0; rec_ready = 1'b1;
        test_reset();
        test_glitch();
        test_single_circle();
        test_two_circles();
        test_timestamp();
        test_overflow();
        test_reset_mid_report();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

endmodule
